// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake, Z/C/V/N flags and idle SLEEP state.
module alu_pipe #(
  parameter int WIDTH       = 8,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg,
  output logic             sleep
);
  localparam int M = WIDTH - 1;
  typedef enum logic {ACTIVE, SLEEP} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, r;
  logic [WIDTH:0]   sum, dif;
  logic             s2_adv, s1_adv, accept, idle, c, v;
  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = s1_valid & s2_adv;
  assign in_ready = en & (state == ACTIVE) & (!s1_valid | s2_adv);
  assign accept   = in_valid & in_ready;
  assign idle     = !in_valid & !s1_valid & !out_valid;
  assign sleep    = state == SLEEP;
  assign sum      = {1'b0, s1_a} + {1'b0, s1_b};
  assign dif      = {1'b0, s1_a} - {1'b0, s1_b};
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (s1_op)
      3'd0: begin
        r = sum[M:0];
        c = sum[WIDTH];
        v = (s1_a[M] == s1_b[M]) & (r[M] != s1_a[M]);
      end
      3'd1: begin
        r = dif[M:0];
        c = dif[WIDTH];
        v = (s1_a[M] != s1_b[M]) & (r[M] != s1_a[M]);
      end
      3'd2: r = s1_a & s1_b;
      3'd3: r = s1_a | s1_b;
      3'd4: r = s1_a ^ s1_b;
      3'd5: r = ~s1_a;
      3'd6: begin
        r = {s1_a[M-1:0], 1'b0};
        c = s1_a[M];
      end
      default: begin
        r = {1'b0, s1_a[M:1]};
        c = s1_a[0];
      end
    endcase
  end
  // Idle counter only runs in ACTIVE; it stops at IDLE_CYCLES-1 because that value forces SLEEP.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    if (state == SLEEP) state_nx = (in_valid & en) ? ACTIVE : SLEEP;
    else if (idle) begin
      if (cnt >= CNT_W'(IDLE_CYCLES - 1)) state_nx = SLEEP;
      else cnt_nx = cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACTIVE;
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      neg       <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= op;
        s1_a     <= a;
        s1_b     <= b;
      end else if (s1_adv) s1_valid <= 1'b0;
      if (s2_adv) out_valid <= s1_valid;
      // Result registers load only when a real operation moves in, so they hold while idle.
      if (s1_adv) begin
        y     <= r;
        zero  <= r == '0;
        carry <= c;
        ovf   <= v;
        neg   <= r[M];
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe; expected results queued at accept, checked on delivery.
module tb_alu_pipe;
  logic       clk = 0, rst_n = 1, en = 1, in_valid = 0, out_ready = 1;
  logic [2:0] op = '0;
  logic [7:0] a = '0, b = '0, y;
  logic       in_ready, out_valid, zero, carry, ovf, neg, sleep;
  logic [11:0] exp_q[$];
  logic [11:0] e;
  int compared = 0, mismatched = 0;

  alu_pipe #(.WIDTH(8), .IDLE_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .carry(carry), .ovf(ovf), .neg(neg), .sleep(sleep)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib);
    int s = 0, ss = 0;
    logic [7:0] r = '0;
    logic c = 0, v = 0;
    case (o)
      3'd0: begin
        s = int'(ia) + int'(ib); ss = int'($signed(ia)) + int'($signed(ib));
        r = s[7:0]; c = s > 255; v = ss > 127 || ss < -128;
      end
      3'd1: begin
        s = int'(ia) - int'(ib); ss = int'($signed(ia)) - int'($signed(ib));
        r = s[7:0]; c = ia < ib; v = ss > 127 || ss < -128;
      end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = ~ia;
      3'd6: begin r = ia << 1; c = ia[7]; end
      default: begin r = ia >> 1; c = ia[0]; end
    endcase
    return {r, r == 8'h00, c, v, r[7]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL result_unexpected: got y=%h zcvn=%b, no result expected", y, {zero, carry, ovf, neg});
      end else begin
        e = exp_q.pop_front();
        if ({y, zero, carry, ovf, neg} !== e) begin
          mismatched++;
          $display("FAIL result: got y=%h zcvn=%b, expected y=%h zcvn=%b", y, {zero, carry, ovf, neg}, e[11:4], e[3:0]);
        end
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    int t = 0;
    op = o; a = x; b = z; in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, t);
    end else exp_q.push_back(model(o, x, z));
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); #1; t++; end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    compared += 4;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    if (y !== 8'h00) begin mismatched++; $display("FAIL reset_y: got %h, expected 00", y); end
    if ({zero, carry, ovf, neg} !== 4'b0000) begin mismatched++; $display("FAIL reset_flags: got %b, expected 0000", {zero, carry, ovf, neg}); end
    if (sleep !== 1'b0) begin mismatched++; $display("FAIL reset_sleep: got %b, expected 0", sleep); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_basic();
    op = 3'd0; a = 8'd5; b = 8'd3; in_valid = 1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL basic_in_ready: got %b, expected 1", in_ready); end
    exp_q.push_back(model(3'd0, 8'd5, 8'd3));
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_latency_early: out_valid=%b, expected 0", out_valid); end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_latency: out_valid=%b, expected 1", out_valid); end
    @(posedge clk); #1;
    wait_drain();
    @(posedge clk); #1;
  endtask

  task automatic test_flags();
    send(3'd1, 8'h03, 8'h05);
    send(3'd0, 8'hFF, 8'h01);
    send(3'd0, 8'h7F, 8'h01);
    send(3'd6, 8'h81, 8'h00);
    send(3'd7, 8'h01, 8'h00);
    wait_drain();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    fork
      for (int i = 0; i < 8; i++) send(3'(i), 8'd5, 8'd3);
      begin
        int t = 0;
        do begin @(negedge clk); t++; end while (!out_valid && t < 20);
        for (int k = 0; k < 8; k++) begin
          if (k > 0) @(negedge clk);
          compared++;
          if (out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_gap: out_valid=%b at result %0d, expected 1", out_valid, k); end
        end
      end
    join
    wait_drain();
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [7:0] y_hold;
    out_ready = 0;
    fork
      begin send(3'd0, 8'd5, 8'd3); send(3'd1, 8'd3, 8'd5); send(3'd2, 8'hF0, 8'h3C); end
      begin
        repeat (4) @(negedge clk);
        compared += 3;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready: got %b, expected 0", in_ready); end
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stall_out_valid: got %b, expected 1", out_valid); end
        if (y !== 8'h08) begin mismatched++; $display("FAIL stall_head: got y=%h, expected 08", y); end
        y_hold = y;
        @(negedge clk);
        compared++;
        if (y !== y_hold) begin mismatched++; $display("FAIL stall_stable: got y=%h, expected %h", y, y_hold); end
        @(posedge clk); #1 out_ready = 1;
      end
    join
    wait_drain();
  endtask

  task automatic test_sleep();
    int t = 0;
    do begin @(negedge clk); t++; end while (out_valid && t < 20);
    repeat (15) @(negedge clk);
    compared++;
    if (sleep !== 1'b0) begin mismatched++; $display("FAIL sleep_early: got %b after 15 idle cycles, expected 0", sleep); end
    @(negedge clk);
    compared += 2;
    if (sleep !== 1'b1) begin mismatched++; $display("FAIL sleep_enter: got %b after 16 idle cycles, expected 1", sleep); end
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL sleep_in_ready: got %b, expected 0", in_ready); end
    @(posedge clk); #1 op = 3'd0; a = 8'hFF; b = 8'h01; in_valid = 1;
    @(negedge clk);
    compared += 2;
    if (sleep !== 1'b1) begin mismatched++; $display("FAIL wake_same_cycle_sleep: got %b, expected 1", sleep); end
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL wake_same_cycle_ready: got %b, expected 0", in_ready); end
    @(negedge clk);
    compared += 2;
    if (sleep !== 1'b0) begin mismatched++; $display("FAIL wake_sleep: got %b, expected 0", sleep); end
    if (in_ready !== 1'b1) begin mismatched++; $display("FAIL wake_in_ready: got %b, expected 1", in_ready); end
    exp_q.push_back(model(3'd0, 8'hFF, 8'h01));
    @(posedge clk); #1 in_valid = 0;
    wait_drain();
    @(posedge clk); #1 en = 0; op = 3'd3; a = 8'h11; b = 8'h22; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared += 2;
      if (in_ready !== 1'b0) begin mismatched++; $display("FAIL en_low_ready: got %b, expected 0", in_ready); end
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL en_low_out_valid: got %b, expected 0", out_valid); end
    end
    @(posedge clk); #1 in_valid = 0; en = 1;
  endtask

  task automatic test_async_reset();
    send(3'd0, 8'h01, 8'h02);
    send(3'd3, 8'h10, 8'h01);
    #2 rst_n = 0;
    #1;
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL async_out_valid: got %b, expected 0", out_valid); end
    if (y !== 8'h00) begin mismatched++; $display("FAIL async_y: got %h, expected 00", y); end
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL async_stale: out_valid=%b cycle %0d, expected 0", out_valid, k); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_stall();
    test_sleep();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
